// File: rtl/amm_burst_responder.sv
// amm_burst_responder: Avalon-MM burst slave backed by an internal word memory,
// with fixed read latency, read-path error injection and protocol-violation flag.
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   amm_address_i                  byte address; word index = address[ADDR_B_W +: MEM_WORDS_W]
//   amm_read_i, amm_write_i        read / write request
//   amm_writedata_i, amm_byteenable_i, amm_burstcount_i   write data, byte lanes, beats
//   amm_waitrequest_o              stall (high while a read burst is in flight)
//   amm_readdata_o, amm_readdatavalid_o   read beat and qualifier (data is 0 when not valid)
//   err_en_i, err_word_i, err_byte_i      invert one byte lane of one word on read
//   proto_err_o                    sticky protocol-violation flag
//   wr_words_o, rd_words_o         stored write beats / delivered read beats
module amm_burst_responder #(
    parameter int AMM_ADDR_W  = 32,
    parameter int AMM_DATA_W  = 512,
    parameter int AMM_BURST_W = 6,
    parameter int MEM_WORDS_W = 8,
    parameter int RD_LATENCY  = 4,
    localparam int DATA_B_W   = AMM_DATA_W / 8,
    localparam int ADDR_B_W   = $clog2(DATA_B_W)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [AMM_ADDR_W-1:0]  amm_address_i,
    input  logic                   amm_read_i,
    input  logic                   amm_write_i,
    input  logic [AMM_DATA_W-1:0]  amm_writedata_i,
    input  logic [DATA_B_W-1:0]    amm_byteenable_i,
    input  logic [AMM_BURST_W-1:0] amm_burstcount_i,
    output logic                   amm_waitrequest_o,
    output logic [AMM_DATA_W-1:0]  amm_readdata_o,
    output logic                   amm_readdatavalid_o,
    input  logic                   err_en_i,
    input  logic [MEM_WORDS_W-1:0] err_word_i,
    input  logic [ADDR_B_W-1:0]    err_byte_i,
    output logic                   proto_err_o,
    output logic [31:0]            wr_words_o,
    output logic [31:0]            rd_words_o
);
    typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_DATA} state_t;

    state_t                 state;
    logic [MEM_WORDS_W-1:0] idx;
    logic [AMM_BURST_W-1:0] left;
    logic [3:0]             lat;
    logic [AMM_DATA_W-1:0]  mem [1 << MEM_WORDS_W];

    logic [MEM_WORDS_W-1:0] req_idx, src_idx;
    logic                   bc_ok, idle_wr, rd_idle, wr_beat, emit, proto_set;
    logic [AMM_DATA_W-1:0]  mask, beat_data;

    assign req_idx = amm_address_i[ADDR_B_W +: MEM_WORDS_W];
    assign bc_ok   = amm_burstcount_i != '0;
    assign idle_wr = state == IDLE && amm_write_i && bc_ok;
    assign rd_idle = state == IDLE && amm_read_i && !amm_write_i && bc_ok;
    assign wr_beat = idle_wr || (state == WRITE && amm_write_i);
    // IDLE uses the request address directly; bursts use the latched running index
    assign src_idx = state == IDLE ? req_idx : idx;
    // A beat is launched one edge ahead of its valid cycle; with latency 1 that is the accept edge
    assign emit = (rd_idle && RD_LATENCY == 1) ||
                  (state == RD_WAIT && lat == 4'd1) ||
                  (state == RD_DATA && left != '0);
    assign mask = (err_en_i && src_idx == err_word_i) ?
                  (AMM_DATA_W'(8'hFF) << {err_byte_i, 3'b000}) : '0;
    assign beat_data = mem[src_idx] ^ mask;
    assign proto_set = (state == IDLE && (amm_read_i || amm_write_i) && !bc_ok) ||
                       (state == IDLE && amm_read_i && amm_write_i) ||
                       (state == WRITE && amm_read_i);

    // Memory has no reset so its contents survive a reset pulse
    always_ff @(posedge clk_i) begin
        if (rst_n_i && wr_beat)
            for (int b = 0; b < DATA_B_W; b++)
                if (amm_byteenable_i[b])
                    mem[src_idx][b*8 +: 8] <= amm_writedata_i[b*8 +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state               <= IDLE;
            idx                 <= '0;
            left                <= '0;
            lat                 <= '0;
            amm_waitrequest_o   <= 1'b0;
            amm_readdatavalid_o <= 1'b0;
            amm_readdata_o      <= '0;
            proto_err_o         <= 1'b0;
            wr_words_o          <= '0;
            rd_words_o          <= '0;
        end else begin
            proto_err_o         <= proto_err_o | proto_set;
            wr_words_o          <= wr_words_o + 32'(wr_beat);
            rd_words_o          <= rd_words_o + 32'(emit);
            amm_readdatavalid_o <= emit;
            amm_readdata_o      <= emit ? beat_data : '0;
            case (state)
                IDLE: begin
                    if (idle_wr) begin
                        idx   <= req_idx + MEM_WORDS_W'(1);
                        left  <= amm_burstcount_i - AMM_BURST_W'(1);
                        state <= amm_burstcount_i == AMM_BURST_W'(1) ? IDLE : WRITE;
                    end else if (rd_idle) begin
                        idx               <= req_idx + MEM_WORDS_W'(emit);
                        left              <= amm_burstcount_i - AMM_BURST_W'(emit);
                        lat               <= 4'(RD_LATENCY - 1);
                        state             <= emit ? RD_DATA : RD_WAIT;
                        amm_waitrequest_o <= 1'b1;
                    end
                end
                WRITE: begin
                    if (amm_write_i) begin
                        idx  <= idx + MEM_WORDS_W'(1);
                        left <= left - AMM_BURST_W'(1);
                        if (left == AMM_BURST_W'(1))
                            state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    lat <= lat - 4'd1;
                    if (lat == 4'd1) begin
                        idx   <= idx + MEM_WORDS_W'(1);
                        left  <= left - AMM_BURST_W'(1);
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (left != '0) begin
                        idx  <= idx + MEM_WORDS_W'(1);
                        left <= left - AMM_BURST_W'(1);
                    end else begin
                        state             <= IDLE;
                        amm_waitrequest_o <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_amm_burst_responder.sv
// tb_amm_burst_responder: scoreboard bench for amm_burst_responder; stimulus pushes
// expected read beats (data and cycle) into a queue, a negedge monitor pops and compares.
module tb_amm_burst_responder;
    localparam int AW = 32, DW = 512, BW = 6, MW = 8, L = 4;
    localparam int NB = DW / 8, AB = $clog2(NB), DEPTH = 1 << MW;

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [AW-1:0] addr = '0;
    logic          rd = 0, wr = 0;
    logic [DW-1:0] wdata = '0;
    logic [NB-1:0] bte = '0;
    logic [BW-1:0] bc = '0;
    logic          wreq, rdv, proto;
    logic [DW-1:0] rdata;
    logic          err_en = 0;
    logic [MW-1:0] err_word = '0;
    logic [AB-1:0] err_byte = '0;
    logic [31:0]   wr_words, rd_words;

    exp_t          q[$];
    exp_t          e;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wbuf [16];
    int            checks = 0, errors = 0, cyc = 0, vbeats = 0, exp_wr = 0, exp_rd = 0;
    bit            mon_on = 0;

    amm_burst_responder #(.AMM_ADDR_W(AW), .AMM_DATA_W(DW), .AMM_BURST_W(BW),
                          .MEM_WORDS_W(MW), .RD_LATENCY(L)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .amm_address_i(addr), .amm_read_i(rd),
        .amm_write_i(wr), .amm_writedata_i(wdata), .amm_byteenable_i(bte),
        .amm_burstcount_i(bc), .amm_waitrequest_o(wreq), .amm_readdata_o(rdata),
        .amm_readdatavalid_o(rdv), .err_en_i(err_en), .err_word_i(err_word),
        .err_byte_i(err_byte), .proto_err_o(proto), .wr_words_o(wr_words),
        .rd_words_o(rd_words));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (rdv) begin
                vbeats++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid act=1 exp=0");
                end else begin
                    e = q.pop_front();
                    chk("rd_data", rdata, e.d);
                    chk("rd_cycle", DW'(cyc), DW'(e.cyc));
                end
            end else
                chk("rdata_zero_when_invalid", rdata, '0);
        end
    end

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {NB{b}};
    endfunction

    task automatic chk_cnt();
        chk("wr_words", DW'(wr_words), DW'(exp_wr));
        chk("rd_words", DW'(rd_words), DW'(exp_rd));
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1;
        exp_wr = 0;
        exp_rd = 0;
        chk("proto_after_reset", DW'(proto), DW'(0));
    endtask

    // n==0 issues one cycle with burstcount 0; rd_beat raises read on that beat index
    task automatic wr_burst(input int w, input int n, input logic [NB-1:0] be, input int rd_beat);
        wr = 1;
        addr = AW'(w * NB);
        bc = BW'(n);
        bte = be;
        for (int i = 0; i < (n == 0 ? 1 : n); i++) begin
            wdata = wbuf[i];
            rd = (i == rd_beat);
            @(posedge clk);
            #1;
        end
        wr = 0;
        rd = 0;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < NB; b++)
                if (be[b]) model[(w + i) % DEPTH][b*8 +: 8] = wbuf[i][b*8 +: 8];
        exp_wr += n;
    endtask

    task automatic rd_issue(input int w, input int n);
        int ac;
        rd = 1;
        addr = AW'(w * NB);
        bc = BW'(n);
        @(posedge clk);
        #1;
        ac = cyc;
        rd = 0;
        for (int i = 0; i < n; i++) begin
            int k = (w + i) % DEPTH;
            logic [DW-1:0] m = (err_en && k == int'(err_word)) ? (DW'(8'hFF) << (int'(err_byte) * 8)) : '0;
            q.push_back('{model[k] ^ m, ac + L - 1 + i});
        end
        exp_rd += n;
        if (n > 0) chk("waitreq_busy", DW'(wreq), DW'(1));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && (q.size() != 0 || wreq); i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() != 0 || wreq) begin
            checks++;
            errors++;
            $display("FAIL read_timeout act=%0d pending exp=0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_burst(input int w, input int n);
        rd_issue(w, n);
        wait_done();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitreq", DW'(wreq), DW'(0));
        chk("rst_valid", DW'(rdv), DW'(0));
        chk("rst_rdata", rdata, '0);
        chk("rst_proto", DW'(proto), DW'(0));
        chk_cnt();
        rst_n = 1;
        mon_on = 1;

        for (int i = 0; i < 4; i++) wbuf[i] = {16{32'hC0DE0000 + 32'(i) * 32'h1111}};
        wr_burst(0, 4, '1, -1);
        rd_burst(0, 4);
        chk_cnt();

        wbuf[0] = fill(8'hAA);
        wr_burst(5, 1, '1, -1);
        wbuf[0] = fill(8'h55);
        wr_burst(5, 1, NB'(1), -1);
        rd_burst(5, 1);

        for (int i = 0; i < 3; i++) wbuf[i] = {16{32'h7E570000 + 32'(i)}};
        wr_burst(DEPTH - 1, 3, '1, -1);
        rd_burst(DEPTH - 1, 3);
        rd_burst(1, 1);
        chk_cnt();

        wbuf[0] = fill(8'hAA);
        wr_burst(5, 1, '1, -1);
        err_en = 1;
        err_word = MW'(5);
        err_byte = AB'(3);
        rd_burst(5, 1);
        rd_burst(4, 3);
        err_en = 0;
        rd_burst(5, 1);

        chk("proto_clean", DW'(proto), DW'(0));
        wbuf[0] = fill(8'h11);
        wr_burst(5, 0, '1, -1);
        rd_burst(5, 0);
        chk("proto_bc0", DW'(proto), DW'(1));
        chk_cnt();
        rd_burst(5, 1);

        do_reset();
        wbuf[0] = fill(8'h3C);
        wr_burst(7, 1, '1, 0);
        repeat (L + 2) @(posedge clk);
        #1;
        chk("proto_rd_wr", DW'(proto), DW'(1));
        rd_burst(7, 1);

        do_reset();
        for (int i = 0; i < 2; i++) wbuf[i] = fill(8'(8'h60 + i));
        wr_burst(20, 2, '1, 1);
        repeat (L + 2) @(posedge clk);
        #1;
        chk("proto_rd_in_write", DW'(proto), DW'(1));
        rd_burst(20, 2);

        do_reset();
        for (int i = 0; i < 8; i++) wbuf[i] = {16{32'hBEEF0000 + 32'(i) * 32'h0101}};
        wr_burst(40, 8, '1, -1);
        base = vbeats;
        rd_issue(40, 8);
        for (int i = 0; i < 50 && vbeats < base + 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("beats_before_reset", DW'(vbeats), DW'(base + 2));
        rst_n = 0;
        @(posedge clk);
        #1;
        q.delete();
        chk("mid_rst_valid", DW'(rdv), DW'(0));
        chk("mid_rst_waitreq", DW'(wreq), DW'(0));
        chk("mid_rst_rdata", rdata, '0);
        exp_wr = 0;
        exp_rd = 0;
        chk_cnt();
        rst_n = 1;
        @(posedge clk);
        #1;
        rd_burst(40, 8);
        chk_cnt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/amm_burst_responder.md
AMM_BURST_RESPONDER -- requirements
Module: amm_burst_responder

Interface
REQ-001 The block SHALL have parameter AMM_ADDR_W, default 32, meaning byte-address width of the Avalon-MM slave port.
REQ-002 The block SHALL have parameter AMM_DATA_W, default 512, meaning data width; DATA_B_W = AMM_DATA_W/8 and ADDR_B_W = clog2(DATA_B_W).
REQ-003 The block SHALL have parameter AMM_BURST_W, default 6, meaning burstcount width.
REQ-004 The block SHALL have parameter MEM_WORDS_W, default 8, meaning log2 of the internal word count.
REQ-005 The block SHALL have parameter RD_LATENCY, default 4 (range 1..15), meaning cycles from read accept to first readdatavalid.
REQ-006 The block SHALL have a single clock; reset is synchronous and active-low.
REQ-007 clk_i  in  1  clock; all logic is on the rising edge.
REQ-008 rst_n_i  in  1  synchronous active-low reset.
REQ-009 amm_address_i  in  AMM_ADDR_W  byte address; word index = address[ADDR_B_W +: MEM_WORDS_W].
REQ-010 amm_read_i / amm_write_i  in  1 each  read / write request.
REQ-011 amm_writedata_i  in  AMM_DATA_W  write data.
REQ-012 amm_byteenable_i  in  DATA_B_W  per-byte write enable.
REQ-013 amm_burstcount_i  in  AMM_BURST_W  beats in the burst.
REQ-014 amm_waitrequest_o  out  1  stall.
REQ-015 amm_readdata_o  out  AMM_DATA_W  read data.
REQ-016 amm_readdatavalid_o  out  1  read data qualifier.
REQ-017 err_en_i  in  1  error injection enable.
REQ-018 err_word_i  in  MEM_WORDS_W  word index to corrupt on read.
REQ-019 err_byte_i  in  ADDR_B_W  byte lane to invert on read.
REQ-020 proto_err_o  out  1  sticky protocol-violation flag.
REQ-021 wr_words_o / rd_words_o  out  32 each  count of accepted write beats / delivered read beats.

Function
REQ-022 The FSM SHALL have states IDLE, WRITE, RD_WAIT and RD_DATA.
REQ-023 In IDLE, amm_waitrequest_o SHALL be 0; write with burstcount>=1 SHALL store beat 0, latch word index+1 and remaining = burstcount-1, and go to WRITE, or stay in IDLE if burstcount==1.
REQ-024 In WRITE, waitrequest SHALL be 0; each cycle with write=1 SHALL store one beat at the current index; the last beat returns to IDLE; cycles with write=0 SHALL hold state.
REQ-025 A write SHALL update only bytes with byteenable=1; other bytes SHALL keep their prior value.
REQ-026 In IDLE, read with burstcount>=1 SHALL latch the index and count, load the latency counter with RD_LATENCY-1, and go to RD_WAIT; waitrequest SHALL be 1 from the next cycle until return to IDLE.
REQ-027 In RD_WAIT, the counter SHALL decrement each cycle; at 0, the FSM SHALL go to RD_DATA, so the first readdatavalid occurs exactly RD_LATENCY cycles after the accept cycle.
REQ-028 RD_DATA SHALL drive one beat per cycle with consecutive indices and readdatavalid=1, then return to IDLE after the last beat with readdatavalid=0 the next cycle.
REQ-029 The word index SHALL wrap modulo 2^MEM_WORDS_W within a burst.
REQ-030 When err_en_i=1 and the beat index equals err_word_i, byte err_byte_i of readdata SHALL be bit-inverted; memory SHALL not be modified.
REQ-031 burstcount==0 in IDLE SHALL be ignored (no state change) and SHALL set proto_err_o.
REQ-032 read and write both high in IDLE SHALL give the write priority, drop the read, and set proto_err_o.
REQ-033 read asserted during WRITE SHALL be ignored and SHALL set proto_err_o.
REQ-034 amm_readdata_o SHALL be 0 whenever readdatavalid=0.
REQ-035 wr_words_o SHALL increment per stored beat and rd_words_o per valid beat; both SHALL wrap at 2^32.

Reset
REQ-036 rst_n_i=0 SHALL force IDLE, waitrequest=0, readdatavalid=0, readdata=0, proto_err_o=0, counters=0, and abort any burst in progress; memory contents SHALL be retained and are undefined after power-up.

Verification
REQ-037 Write burst of 4 at address 0x0 with data W0..W3, all byteenable=1, then read burst of 4 at 0x0 -> readdatavalid rises exactly RD_LATENCY cycles after accept; data W0..W3 in 4 consecutive cycles; wr_words_o=4, rd_words_o=4.
REQ-038 Write 0xAA.. to word 5, then write 0x55.. with byteenable=0x1 -> read word 5: byte 0=0x55, all other bytes 0xAA.
REQ-039 Write burst of 3 starting at word 2^MEM_WORDS_W-1 -> data lands at the last word, word 0 and word 1; read-back matches.
REQ-040 Inject error: err_en_i=1, err_word_i=5, err_byte_i=3 over word filled with 0xAA -> byte 3 reads 0x55, other bytes 0xAA; re-read with err_en_i=0 returns all 0xAA.
REQ-041 Assert read and write together in IDLE -> write stored, no readdatavalid, proto_err_o=1 until reset.
REQ-042 Reset asserted mid read burst after 2 of 8 beats -> next cycle readdatavalid=0, waitrequest=0, counters=0; a subsequent read returns the previously written data.
